// File: rtl/conv1_window_ctrl.sv
// Purpose: turns a raster-order pixel stream into 3x3 no-padding windows for the conv1 datapath.
// Latency: a window is valid one cycle after its bottom-right pixel (row>=2, col>=2) is accepted.
// Backpressure: registered window with no skid; in_ready = !valid_in_buf || out_ready while filling/running.
// Optional: define CONV1_WIN_CNT_EN to add win_count/cnt_err (consumed-window counter and check).
module conv1_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] pixel_0,
  output logic [PIX_W-1:0] pixel_1,
  output logic [PIX_W-1:0] pixel_2,
  output logic [PIX_W-1:0] pixel_3,
  output logic [PIX_W-1:0] pixel_4,
  output logic [PIX_W-1:0] pixel_5,
  output logic [PIX_W-1:0] pixel_6,
  output logic [PIX_W-1:0] pixel_7,
  output logic [PIX_W-1:0] pixel_8,
  output logic             valid_in_buf,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done
`ifdef CONV1_WIN_CNT_EN
  ,
  output logic [9:0]       win_count,
  output logic             cnt_err
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            valid_q, valid_d;
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];

  // Line buffers: top holds row r-2, mid holds row r-1, indexed by column.
  logic [PIX_W-1:0] lb_top_q [IMG_W];
  logic [PIX_W-1:0] lb_mid_q [IMG_W];

  logic accept;
  logic consume;
  logic accepting_state;

  assign accepting_state = (state_q == FILL) || (state_q == RUN);
  assign in_ready        = accepting_state && (!valid_q || out_ready);
  assign accept          = in_valid && in_ready;
  assign consume         = valid_q && out_ready;
  assign busy            = (state_q != IDLE);
  assign frame_done      = (state_q == DONE);
  assign valid_in_buf    = valid_q;

  assign pixel_0 = win_q[0];
  assign pixel_1 = win_q[1];
  assign pixel_2 = win_q[2];
  assign pixel_3 = win_q[3];
  assign pixel_4 = win_q[4];
  assign pixel_5 = win_q[5];
  assign pixel_6 = win_q[6];
  assign pixel_7 = win_q[7];
  assign pixel_8 = win_q[8];

  // Next-state: FSM, raster counters, window shift and window-valid tracking.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    win_d   = win_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      FILL: begin
        if (accept && row_q == ROW_ONE && col_q == COL_LAST) state_d = RUN;
      end
      RUN: begin
        if (accept && row_q == ROW_LAST && col_q == COL_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (consume) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      // Raster position advances; row wraps to 0 after the last pixel of the frame.
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
      end else begin
        col_d = col_q + CW'(1);
      end

      // Shift window left by one column; new right column comes from the line buffers.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb_top_q[col_q];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb_mid_q[col_q];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_pixel;
    end

    // A load wins over a consume in the same cycle, so valid stays high.
    if (accept && row_q >= ROW_TWO && col_q >= COL_TWO) begin
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // Control and window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  // Line-buffer storage: contents need no reset since every frame refills rows 0..1 first.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top_q[col_q] <= lb_mid_q[col_q];
      lb_mid_q[col_q] <= in_pixel;
    end
  end

`ifdef CONV1_WIN_CNT_EN
  localparam logic [9:0] NWIN = 10'((IMG_W - 2) * (IMG_H - 2));

  logic [9:0] win_count_q, win_count_d;
  logic       cnt_err_q, cnt_err_d;

  // Consumed-window count and sticky mismatch flag, both cleared by an accepted start.
  always_comb begin
    win_count_d = win_count_q;
    cnt_err_d   = cnt_err_q;
    if (state_q == IDLE && start) begin
      win_count_d = '0;
      cnt_err_d   = 1'b0;
    end else begin
      if (consume) win_count_d = win_count_q + 10'd1;
      if (state_q == DONE && win_count_q != NWIN) cnt_err_d = 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_count_q <= '0;
      cnt_err_q   <= 1'b0;
    end else begin
      win_count_q <= win_count_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign win_count = win_count_q;
  assign cnt_err   = cnt_err_q;
`endif

endmodule

// File: tb/tb_conv1_window_ctrl.sv
// Bench for conv1_window_ctrl: drives full frames with random valid/ready patterns.
// Expected windows come from an image array indexed by (row, col) of each accepted pixel.
// Checks reset, window content/latency, stall stability, frame_done/busy, idle ignoring and abort.
module tb_conv1_window_ctrl;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int P    = 8;
  localparam int NWIN = (W - 2) * (H - 2);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [P-1:0] in_pixel = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, valid_in_buf, busy, frame_done;
  logic [P-1:0] pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8;
`ifdef CONV1_WIN_CNT_EN
  logic [9:0]   win_count;
  logic         cnt_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [P-1:0] img [H][W];
  logic [P-1:0] pix [9];

  assign pix[0] = pixel_0;
  assign pix[1] = pixel_1;
  assign pix[2] = pixel_2;
  assign pix[3] = pixel_3;
  assign pix[4] = pixel_4;
  assign pix[5] = pixel_5;
  assign pix[6] = pixel_6;
  assign pix[7] = pixel_7;
  assign pix[8] = pixel_8;

  always #5 clk = ~clk;

  conv1_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_pixel     (in_pixel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pixel_0      (pixel_0),
    .pixel_1      (pixel_1),
    .pixel_2      (pixel_2),
    .pixel_3      (pixel_3),
    .pixel_4      (pixel_4),
    .pixel_5      (pixel_5),
    .pixel_6      (pixel_6),
    .pixel_7      (pixel_7),
    .pixel_8      (pixel_8),
    .valid_in_buf (valid_in_buf),
    .out_ready    (out_ready),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef CONV1_WIN_CNT_EN
    ,
    .win_count    (win_count),
    .cnt_err      (cnt_err)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (valid_in_buf !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_in_buf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (pix[k] !== '0) begin bad++; $display("FAIL reset_pixel_%0d got=%0d exp=0", k, pix[k]); end
    end
`ifdef CONV1_WIN_CNT_EN
    total++; if (win_count !== 10'd0) begin bad++; $display("FAIL reset_win_count got=%0d exp=0", win_count); end
    total++; if (cnt_err !== 1'b0) begin bad++; $display("FAIL reset_cnt_err got=%b exp=0", cnt_err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // in_valid while idle must never be accepted, and nothing may start.
  task automatic test_idle_ignore();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'(i % 2);
      in_pixel  = P'($urandom);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready i=%0d got=%b exp=0", i, in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy i=%0d got=%b exp=0", i, busy); end
      total++; if (valid_in_buf !== 1'b0) begin bad++; $display("FAIL idle_valid i=%0d got=%b exp=0", i, valid_in_buf); end
    end
    in_valid = 1'b0;
  endtask

  // One frame: rnd_pix random pixel data, stall toggles out_ready and randomizes in_valid,
  // rnd_start injects start pulses while busy, abort_row>0 pulls reset when that row begins.
  task automatic test_frame(input bit rnd_pix, input bit stall, input bit rnd_start, input int abort_row);
    int acc_n, cons_n, cyc, r, c;
    bit exp_v, exp_fd, exp_busy, finishing, done, ir_exp, acc, cons;
    logic [P-1:0] exp_w [9];

    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        img[rr][cc] = rnd_pix ? P'($urandom) : P'((rr * W + cc) & 255);
    for (int k = 0; k < 9; k++) exp_w[k] = '0;

    @(negedge clk);
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;

    acc_n = 0; cons_n = 0; cyc = 0;
    exp_v = 1'b0; exp_fd = 1'b0; exp_busy = 1'b1; finishing = 1'b0; done = 1'b0;

    while (!done && cyc < 20000) begin
      total++; if (valid_in_buf !== exp_v) begin bad++; $display("FAIL valid cyc=%0d acc=%0d got=%b exp=%b", cyc, acc_n, valid_in_buf, exp_v); end
      if (exp_v) begin
        for (int k = 0; k < 9; k++) begin
          total++;
          if (pix[k] !== exp_w[k]) begin bad++; $display("FAIL window_pixel_%0d cyc=%0d acc=%0d got=%0d exp=%0d", k, cyc, acc_n, pix[k], exp_w[k]); end
        end
      end
      total++; if (frame_done !== exp_fd) begin bad++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end

      if (finishing) begin
        done = 1'b1;
      end else if (exp_fd) begin
        exp_fd    = 1'b0;
        exp_busy  = 1'b0;
        finishing = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        cyc++;
      end else if (abort_row > 0 && acc_n == abort_row * W) begin
        in_valid = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        #1;
        total++; if (valid_in_buf !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", valid_in_buf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b exp=0", in_ready); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL abort_frame_done got=%b exp=0", frame_done); end
        for (int k = 0; k < 9; k++) begin
          total++;
          if (pix[k] !== '0) begin bad++; $display("FAIL abort_pixel_%0d got=%0d exp=0", k, pix[k]); end
        end
`ifdef CONV1_WIN_CNT_EN
        total++; if (win_count !== 10'd0) begin bad++; $display("FAIL abort_win_count got=%0d exp=0", win_count); end
`endif
        #1;
        rst_n = 1'b1;
        return;
      end else begin
        out_ready = stall ? 1'(cyc % 2) : 1'b1;
        in_valid  = stall ? ($urandom_range(1, 0) == 1) : 1'b1;
        in_pixel  = (acc_n < H * W) ? img[acc_n / W][acc_n % W] : P'($urandom);
        start     = rnd_start && ($urandom_range(7, 0) == 0);
        #1;
        ir_exp = (acc_n < H * W) && (!exp_v || out_ready);
        total++; if (in_ready !== ir_exp) begin bad++; $display("FAIL in_ready cyc=%0d acc=%0d got=%b exp=%b", cyc, acc_n, in_ready, ir_exp); end
        acc  = in_valid && ir_exp;
        cons = exp_v && out_ready;
        if (cons) cons_n++;
        if (acc) begin
          r = acc_n / W;
          c = acc_n % W;
          if (r >= 2 && c >= 2) begin
            exp_v = 1'b1;
            for (int k = 0; k < 9; k++) exp_w[k] = img[r - 2 + k / 3][c - 2 + k % 3];
          end else if (cons) begin
            exp_v = 1'b0;
          end
          acc_n++;
        end else if (cons) begin
          exp_v = 1'b0;
        end
        exp_fd = cons && (cons_n == NWIN);
        @(negedge clk);
        cyc++;
      end
    end

    start    = 1'b0;
    in_valid = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL frame_timeout cyc=%0d acc=%0d cons=%0d", cyc, acc_n, cons_n); end
    total++; if (cons_n != NWIN) begin bad++; $display("FAIL window_count got=%0d exp=%0d", cons_n, NWIN); end
`ifdef CONV1_WIN_CNT_EN
    total++; if (win_count !== 10'(NWIN)) begin bad++; $display("FAIL win_count got=%0d exp=%0d", win_count, NWIN); end
    total++; if (cnt_err !== 1'b0) begin bad++; $display("FAIL cnt_err got=%b exp=0", cnt_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_frame(1'b0, 1'b0, 1'b0, 0);
    test_frame(1'b0, 1'b1, 1'b1, 0);
    test_frame(1'b1, 1'b1, 1'b1, 0);
    test_frame(1'b1, 1'b1, 1'b0, 10);
    test_frame(1'b0, 1'b0, 1'b0, 0);
    test_idle_ignore();
    test_frame(1'b1, 1'b1, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
